// File: rtl/observer_pkg.sv
// rtl/observer_pkg.sv - shared mode/state types and constants for the debug observer
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package observer_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'd0,
        MODE_SNAP  = 2'd1,
        MODE_TRACE = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        OBS_IDLE    = 2'd0,
        OBS_ARMED   = 2'd1,
        OBS_CAPTURE = 2'd2,
        OBS_DONE    = 2'd3
    } obs_state_e;

    localparam logic [31:0] ZERO_WORD = `ZeroWord;

endpackage

// File: rtl/observer_trace_buf.sv
// rtl/observer_trace_buf.sv - DEPTH x DATA_W circular trace buffer with occupancy flags
module observer_trace_buf #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrp;
    logic [PTR_W-1:0]  rdp;
    logic [CNT_W-1:0]  cnt;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrp <= '0;
            rdp <= '0;
            cnt <= '0;
        end else if (clr) begin
            wrp <= '0;
            rdp <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wrp <= wrp + 1'b1;
            if (do_rd) rdp <= rdp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wrp] <= wr_data;
    end

    assign rd_data = mem[rdp];
    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/observer_trace.sv
// rtl/observer_trace.sv - probe channel observer with live view, triggered snapshot and trace capture
module observer_trace
    import observer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NUM_CH = 8,
    parameter  int DEPTH  = 16,
    localparam int SEL_W  = $clog2(NUM_CH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [SEL_W-1:0]         ch_sel_i,
    input  logic [1:0]               mode_i,
    input  logic                     arm_i,
    input  logic                     trig_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic [1:0]               state_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     underflow_o
);

    mode_e             mode;
    mode_e             mode_q;
    obs_state_e        state_q;
    obs_state_e        state_d;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] live_q;
    logic              live_vld_q;
    logic [DATA_W-1:0] snap_q;
    logic              underflow_q;
    logic              mode_chg;
    logic              active;
    logic              arm_ok;
    logic              uf_set;
    logic              buf_clr;
    logic              buf_wr;
    logic              buf_rd;
    logic              snap_ld;
    logic [DATA_W-1:0] buf_rd_data;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    logic              buf_full;

    // Unmatched selects fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel_i == SEL_W'(k)) sel_data = ch_data_i[k*DATA_W +: DATA_W];
        end
    end

    assign mode     = mode_e'(mode_i);
    assign mode_chg = (mode != mode_q);
    assign active   = !mode_chg && (mode == MODE_SNAP || mode == MODE_TRACE);
    assign arm_ok   = active && arm_i;
    assign uf_set   = rd_en_i && (mode == MODE_SNAP || mode == MODE_TRACE) &&
                      !(state_q == OBS_DONE && !buf_empty);

    always_comb begin
        state_d = state_q;
        buf_clr = mode_chg;
        buf_wr  = 1'b0;
        buf_rd  = 1'b0;
        snap_ld = 1'b0;
        if (!active) begin
            state_d = OBS_IDLE;
        end else if (arm_i) begin
            state_d = OBS_ARMED;
            buf_clr = 1'b1;
        end else begin
            case (state_q)
                OBS_ARMED: begin
                    if (trig_i) begin
                        if (mode == MODE_SNAP) begin
                            snap_ld = 1'b1;
                            state_d = OBS_DONE;
                        end else begin
                            buf_wr  = 1'b1;
                            state_d = OBS_CAPTURE;
                        end
                    end
                end
                OBS_CAPTURE: begin
                    buf_wr = 1'b1;
                    if (buf_count == CNT_W'(DEPTH - 1)) state_d = OBS_DONE;
                end
                OBS_DONE: buf_rd = rd_en_i && !buf_empty;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OBS_IDLE;
            mode_q      <= MODE_LIVE;
            live_q      <= '0;
            live_vld_q  <= 1'b0;
            snap_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode;
            live_vld_q <= (mode == MODE_LIVE) && !mode_chg;
            if (mode == MODE_LIVE) live_q <= sel_data;
            if (buf_clr)      snap_q <= '0;
            else if (snap_ld) snap_q <= sel_data;
            if (arm_ok)      underflow_q <= 1'b0;
            else if (uf_set) underflow_q <= 1'b1;
        end
    end

    observer_trace_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (sel_data),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .empty   (buf_empty),
        .full    (buf_full)
    );

    // Output view follows the mode seen at the last edge, so a mode switch blanks valid for a cycle.
    always_comb begin
        data_o  = DATA_W'(ZERO_WORD);
        valid_o = 1'b0;
        case (mode_q)
            MODE_LIVE: begin
                data_o  = live_q;
                valid_o = live_vld_q;
            end
            MODE_SNAP: begin
                if (state_q == OBS_DONE) begin
                    data_o  = snap_q;
                    valid_o = 1'b1;
                end
            end
            MODE_TRACE: begin
                if (state_q == OBS_DONE) begin
                    data_o  = buf_rd_data;
                    valid_o = !buf_empty;
                end
            end
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign count_o     = buf_count;
    assign empty_o     = buf_empty;
    assign full_o      = buf_full;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_observer_trace.sv
// tb/tb_observer_trace.sv - self-checking bench for observer_trace
module tb_observer_trace;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 6;
    localparam int DEPTH  = 16;
    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [DATA_W-1:0]        ch [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [SEL_W-1:0]         sel;
    logic [1:0]               mode;
    logic                     arm, trig, rd;
    logic [DATA_W-1:0]        data;
    logic                     valid;
    logic [1:0]               state;
    logic [CNT_W-1:0]         count;
    logic                     empty, full, underflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch[k];
    end

    observer_trace #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data_i   (ch_data),
        .ch_sel_i    (sel),
        .mode_i      (mode),
        .arm_i       (arm),
        .trig_i      (trig),
        .rd_en_i     (rd),
        .data_o      (data),
        .valid_o     (valid),
        .state_o     (state),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .underflow_o (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " data"}, data, 32'h0);
        chk({tag, " valid"}, 32'(valid), 32'h0);
        chk({tag, " state"}, 32'(state), 32'h0);
        chk({tag, " count"}, 32'(count), 32'h0);
        chk({tag, " empty"}, 32'(empty), 32'h1);
        chk({tag, " full"}, 32'(full), 32'h0);
        chk({tag, " underflow"}, 32'(underflow), 32'h0);
    endtask

    // Reference model: observable behaviour tracked with a queue of captured words.
    int          m_mode_prev;
    int          m_phase;
    logic [31:0] m_q [$];
    logic [31:0] m_snap;
    logic [31:0] m_live;
    bit          m_lvld;
    bit          m_uf;

    function automatic logic [31:0] sel_val();
        if (int'(sel) < NUM_CH) return ch[sel];
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_mode_prev = 0;
        m_phase     = 0;
        m_q.delete();
        m_snap = 0;
        m_live = 0;
        m_lvld = 0;
        m_uf   = 0;
    endtask

    task automatic m_step();
        bit          chg;
        bit          act;
        logic [31:0] sd;
        chg = (int'(mode) != m_mode_prev);
        act = !chg && (mode == 2'd1 || mode == 2'd2);
        sd  = sel_val();
        if (mode == 2'd0) m_live = sd;
        m_lvld = (mode == 2'd0) && !chg;
        if (act && arm) m_uf = 0;
        else if (rd && (mode == 2'd1 || mode == 2'd2) && !(m_phase == 3 && m_q.size() > 0)) m_uf = 1;
        if (chg) begin
            m_q.delete();
            m_snap = 0;
        end
        if (!act) begin
            m_phase = 0;
        end else if (arm) begin
            m_phase = 1;
            m_q.delete();
            m_snap = 0;
        end else if (m_phase == 1 && trig) begin
            if (mode == 2'd1) begin
                m_snap  = sd;
                m_phase = 3;
            end else begin
                m_q.push_back(sd);
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_q.push_back(sd);
            if (m_q.size() == DEPTH) m_phase = 3;
        end else if (m_phase == 3 && rd && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        m_mode_prev = int'(mode);
    endtask

    task automatic m_check();
        logic [31:0] ed;
        bit          ev;
        bit          chk_data;
        chk("rnd state", 32'(state), 32'(m_phase));
        chk("rnd count", 32'(count), 32'(m_q.size()));
        chk("rnd empty", 32'(empty), 32'(m_q.size() == 0));
        chk("rnd full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("rnd underflow", 32'(underflow), 32'(m_uf));
        ed = 0;
        ev = 0;
        chk_data = 1;
        case (m_mode_prev)
            0: begin ed = m_live; ev = m_lvld; end
            1: if (m_phase == 3) begin ed = m_snap; ev = 1; end
            2: if (m_phase == 3) begin
                ev = (m_q.size() > 0);
                if (ev) ed = m_q[0];
                else chk_data = 0;
            end
            default: ;
        endcase
        chk("rnd valid", 32'(valid), 32'(ev));
        if (chk_data) chk("rnd data", data, ed);
    endtask

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [31:0]      exp_data;
        logic             exp_valid;
    } live_vec_t;

    live_vec_t tbl [7];

    initial begin
        tbl[0] = '{3'd3, 32'hDEAD_BEEF, 1'b1};
        tbl[1] = '{3'd0, 32'hC0DE_0000, 1'b1};
        tbl[2] = '{3'd5, 32'hC0DE_0005, 1'b1};
        tbl[3] = '{3'd7, 32'h0000_0000, 1'b1};
        tbl[4] = '{3'd6, 32'h0000_0000, 1'b1};
        tbl[5] = '{3'd1, 32'hC0DE_0001, 1'b1};
        tbl[6] = '{3'd3, 32'hDEAD_BEEF, 1'b1};

        rst_n = 1'b0;
        mode = 2'd0; arm = 0; trig = 0; rd = 0; sel = '0;
        for (int k = 0; k < NUM_CH; k++) ch[k] = 32'hC0DE_0000 + k;
        ch[3] = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // LIVE mux table
        for (int i = 0; i < 7; i++) begin
            sel = tbl[i].sel;
            tick();
            chk($sformatf("live[%0d] data", i), data, tbl[i].exp_data);
            chk($sformatf("live[%0d] valid", i), 32'(valid), 32'(tbl[i].exp_valid));
        end

        // SNAP: trigger at ch1 == 105, value held while ch1 ramps on
        mode = 2'd1; sel = 3'd1; ch[1] = 100;
        tick();
        arm = 1; tick(); arm = 0;
        chk("snap armed", 32'(state), 32'd1);
        chk("snap armed valid", 32'(valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            ch[1] = 100 + i;
            trig = (i == 5);
            tick();
        end
        trig = 0;
        chk("snap state", 32'(state), 32'd3);
        chk("snap data", data, 32'd105);
        for (int i = 6; i < 10; i++) begin
            ch[1] = 100 + i;
            tick();
        end
        chk("snap held", data, 32'd105);
        chk("snap valid", 32'(valid), 32'd1);

        // TRACE: 16 consecutive samples from the trigger cycle
        mode = 2'd2; sel = 3'd0;
        tick();
        arm = 1; tick(); arm = 0;
        chk("trace armed", 32'(state), 32'd1);
        chk("trace armed count", 32'(count), 32'd0);
        ch[0] = 32'h10; trig = 1; tick(); trig = 0;
        chk("trace capture", 32'(state), 32'd2);
        for (int i = 1; i < DEPTH; i++) begin
            ch[0] = 32'h10 + i;
            tick();
            if (i == DEPTH - 2) chk("trace still capturing", 32'(state), 32'd2);
        end
        ch[0] = 32'hFFFF;
        chk("trace done", 32'(state), 32'd3);
        chk("trace full", 32'(full), 32'd1);
        chk("trace count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("pop[%0d] data", i), data, 32'h10 + i);
            chk($sformatf("pop[%0d] valid", i), 32'(valid), 32'd1);
            rd = 1; tick(); rd = 0;
        end
        chk("drained empty", 32'(empty), 32'd1);
        chk("drained valid", 32'(valid), 32'd0);
        chk("drained state", 32'(state), 32'd3);
        chk("no underflow yet", 32'(underflow), 32'd0);

        rd = 1; tick(); rd = 0;
        chk("underflow set", 32'(underflow), 32'd1);
        chk("underflow count", 32'(count), 32'd0);
        arm = 1; tick(); arm = 0;
        chk("underflow cleared", 32'(underflow), 32'd0);
        chk("rearm state", 32'(state), 32'd1);

        // arm and trig together from IDLE: arm wins
        mode = 2'd3; tick();
        chk("rsvd valid", 32'(valid), 32'd0);
        chk("rsvd state", 32'(state), 32'd0);
        mode = 2'd2; tick();
        arm = 1; trig = 1; tick(); arm = 0;
        chk("arm+trig state", 32'(state), 32'd1);
        chk("arm+trig count", 32'(count), 32'd0);
        tick(); trig = 0;
        chk("trig after arm", 32'(state), 32'd2);
        repeat (4) tick();
        chk("mid capture count", 32'(count), 32'd5);
        mode = 2'd0; tick();
        chk("abort state", 32'(state), 32'd0);
        chk("abort count", 32'(count), 32'd0);
        chk("abort valid", 32'(valid), 32'd0);
        tick();
        chk("live again valid", 32'(valid), 32'd1);

        // asynchronous reset in the middle of a capture
        mode = 2'd2; tick();
        arm = 1; tick(); arm = 0;
        trig = 1; tick(); trig = 0;
        repeat (4) tick();
        chk("pre-reset count", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async reset");
        mode = 2'd0; arm = 0; trig = 0; rd = 0;
        tick();
        rst_n = 1'b1;

        // randomized run against the reference model
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            m_check();
            if ($urandom_range(59) == 0) mode = 2'($urandom_range(3));
            arm  = ($urandom_range(24) == 0);
            trig = ($urandom_range(5) == 0);
            rd   = ($urandom_range(2) == 0);
            sel  = SEL_W'($urandom_range(7));
            for (int k = 0; k < NUM_CH; k++) ch[k] = $urandom;
            m_step();
            tick();
        end
        m_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/observer_trace.md
Name: observer_trace

Overview:
- Parametrised successor to the single-cycle debug observer: NUM_CH probe channels of DATA_W bits each, with one channel selected for output.
- Adds a trigger-armed snapshot register and a DEPTH-entry trace buffer, so internal values can be captured on an event and read out later.
- Sits beside the CPU core and is fed by PC, IR, ALU operands/result and regfile read data. It drives the board display path and is not on any functional datapath.

Parameters:
- DATA_W, 32, width of each probe channel and of data_o.
- NUM_CH, 8, number of probe channels; must be >= 2.
- DEPTH, 16, trace buffer entries; must be a power of two, >= 2.
- SEL_W, $clog2(NUM_CH), channel-select width; derived, not overridden.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_data_i  in  NUM_CH*DATA_W  packed probes; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_sel_i  in  SEL_W  channel select.
- mode_i  in  2  00 LIVE, 01 SNAP, 10 TRACE, 11 reserved.
- arm_i  in  1  single-cycle arm/re-arm request.
- trig_i  in  1  capture trigger, level-sampled.
- rd_en_i  in  1  pop one trace entry.
- data_o  out  DATA_W  observed value.
- valid_o  out  1  data_o is meaningful.
- state_o  out  2  FSM state encoding.
- count_o  out  CNT_W  trace entries held, 0..DEPTH.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- underflow_o  out  1  sticky flag: rd_en_i was asserted while empty or not in DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; data_o=0, valid_o=0, count_o=0, empty_o=1, full_o=0, underflow_o=0.
  - Snapshot register, read pointer and write pointer all cleared.
- Channel mux: sel_data = channel ch_sel_i; if ch_sel_i >= NUM_CH, sel_data = 0.
- FSM states, encoded on state_o: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- LIVE mode:
  - FSM held in IDLE.
  - data_o <= sel_data every cycle (1-cycle latency); valid_o=1 from the first cycle after reset.
  - arm_i, trig_i and rd_en_i are ignored.
- SNAP mode:
  - IDLE + arm_i -> ARMED.
  - ARMED + trig_i -> snapshot <= sel_data, state -> DONE.
  - In DONE: data_o=snapshot, valid_o=1.
  - In IDLE and ARMED: data_o=0, valid_o=0.
- TRACE mode:
  - IDLE + arm_i -> ARMED; the buffer is cleared on entry to ARMED.
  - ARMED + trig_i -> CAPTURE. The trigger-cycle sel_data is written as entry 0.
  - In CAPTURE, sel_data is written every cycle, wrp++ and count++.
  - The write that makes count==DEPTH moves the FSM to DONE. Entries = DEPTH consecutive cycles starting at the trigger cycle.
  - In DONE: data_o = mem[rdp] (combinational from registered pointer); valid_o = !empty_o.
  - rd_en_i with !empty_o: rdp++, count--; the next entry appears the following cycle.
  - After the last pop: empty_o=1, valid_o=0, FSM stays in DONE.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- mode 11: FSM forced to IDLE, data_o=0, valid_o=0.
- Boundary and priority rules:
  - arm_i in any non-IDLE state of SNAP/TRACE re-arms: go to ARMED and clear the buffer; a captured snapshot is discarded.
  - arm_i and trig_i in the same cycle: arm wins. The trigger is ignored and the FSM is ARMED next cycle.
  - trig_i in CAPTURE or DONE: ignored.
  - rd_en_i when empty, or in any state other than DONE: no pointer change; underflow_o set.
  - underflow_o is cleared only by reset or arm_i.
  - Any mode_i change: FSM aborts to IDLE, buffer cleared, valid_o=0 next cycle.
  - ch_sel_i may change during CAPTURE; each entry records the channel selected in its own cycle.

Decomposition:
- Shared package observer_pkg:
  - mode enum: MODE_LIVE, MODE_SNAP, MODE_TRACE, MODE_RSVD.
  - state enum: OBS_IDLE, OBS_ARMED, OBS_CAPTURE, OBS_DONE.
  - localparam for the reserved-mode zero value (reuses the existing `ZeroWord define via defines.sv).
- One sub-module, observer_trace_buf: DEPTH x DATA_W circular buffer with clr, wr_en, rd_en, count and flags.
- FSM, channel mux and output register stay in observer_trace.

Test Plan:
- Reset then LIVE, ch_data_i ch3=32'hDEAD_BEEF, ch_sel_i=3 -> data_o=32'hDEADBEEF, valid_o=1 one cycle after the select; ch_sel_i=9 with NUM_CH=8 unrealisable, so use NUM_CH=6 build with ch_sel_i=7 -> data_o=0.
- SNAP: arm_i pulse, ch1 ramps +1/cycle from 100, trig_i at ch1=105 -> state_o=3, data_o=105 held while ch1 keeps ramping.
- TRACE, DEPTH=16: arm, trig when ch0=32'h10, ch0 ramps +1/cycle -> state_o reaches 3 after 16 cycles, full_o=1, count_o=16; 16 pops read 32'h10..32'h1F in order; then empty_o=1, valid_o=0.
- 17th pop on empty -> underflow_o=1, count_o stays 0; next arm_i clears underflow_o and gives state_o=1.
- arm_i and trig_i in the same cycle from IDLE -> state_o=1 (not 2), count_o=0; trig_i alone next cycle -> state_o=2.
- Mid-CAPTURE (count_o=5): first case, rst_n low asynchronously -> all outputs immediately at reset values; second case, mode_i switched to LIVE -> state_o=0 and count_o=0 next cycle.
